// File: rtl/dds_wave_gen_if.sv
// Sample-stream bus of the DDS waveform source: strobe/config inputs and the sample output.
interface dds_wave_gen_if #(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DATA_W  = 10
) ();
   logic               en;
   logic               phase_clr;
   logic               cfg_we;
   logic [PHASE_W-1:0] freq_word;
   logic [ADDR_W-1:0]  phase_ofs;
   logic [1:0]         wave_sel;
   logic [7:0]         amp;
   logic [DATA_W-1:0]  dout;
   logic               dout_vld;
   logic               phase_wrap;

   modport master (
      output en, phase_clr, cfg_we, freq_word, phase_ofs, wave_sel, amp,
      input  dout, dout_vld, phase_wrap
   );

   modport slave (
      input  en, phase_clr, cfg_we, freq_word, phase_ofs, wave_sel, amp,
      output dout, dout_vld, phase_wrap
   );
endinterface

// File: rtl/dds_wave_gen.sv
// DDS waveform source: phase accumulator, mirrored quarter-wave sine ROM, square/triangle/saw.
// Optional DDS_AMP_SCALE_EN adds an amplitude-scaling stage (latency 3 -> 4).
module dds_wave_gen #(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DATA_W  = 10
) (
   input logic           clka,
   input logic           rsta_n,
   dds_wave_gen_if.slave bus
);
   localparam int unsigned       QDepth    = 2 ** (ADDR_W - 2);
   localparam int unsigned       MidInt    = 2 ** (DATA_W - 1);
   localparam logic [DATA_W-1:0] Mid       = DATA_W'(MidInt);
   localparam logic [DATA_W-1:0] MidM1     = DATA_W'(MidInt - 1);
   localparam longint            PiHalfQ30 = 64'sd1686629713;

   // ROM word i = round((MID-1)*sin(pi/2*(i+0.5)/QDepth)), evaluated in Q30 by Taylor series.
   function automatic logic [DATA_W-1:0] sine_word(input int unsigned i);
      longint x, x2, term, sum;
      x    = (PiHalfQ30 * longint'(2 * i + 1)) / longint'(2 * QDepth);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int k = 1; k < 8; k++) begin
         term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
         sum  = sum + term;
      end
      return DATA_W'(((longint'(MidInt - 1) * sum) + (longint'(1) <<< 29)) >>> 30);
   endfunction

   logic [DATA_W-1:0] rom [QDepth];
   for (genvar gi = 0; gi < QDepth; gi++) begin : g_rom
      localparam logic [DATA_W-1:0] Word = sine_word(gi);
      assign rom[gi] = Word;
   end

   logic [PHASE_W-1:0] freq_q, freq_d, acc_q, acc_d;
   logic [ADDR_W-1:0]  ofs_q, ofs_d, s0_ofs_q, s0_ofs_d;
   logic [1:0]         sel_q, sel_d, s0_sel_q, s0_sel_d, s1_sel_q, s1_sel_d, s2_sel_q, s2_sel_d;
   logic               s0_vld_q, s0_vld_d, s0_carry_q, s0_carry_d;
   logic               s1_vld_q, s1_vld_d, s1_wrap_q, s1_wrap_d;
   logic               s2_vld_q, s2_vld_d, s2_wrap_q, s2_wrap_d;
   logic [ADDR_W-1:0]  s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
   logic [DATA_W-1:0]  s2_rom_q, s2_rom_d;
   logic [DATA_W-1:0]  dout_q, dout_d;
   logic               vld_q, vld_d, wrap_q, wrap_d;
   logic [PHASE_W:0]   acc_sum;
   logic [ADDR_W-3:0]  raddr;
   logic [ADDR_W-2:0]  tri_t;
   logic [DATA_W-1:0]  wave;

   always_comb begin
      freq_d = freq_q;
      ofs_d  = ofs_q;
      sel_d  = sel_q;
      if (bus.cfg_we) begin
         freq_d = bus.freq_word;
         ofs_d  = bus.phase_ofs;
         sel_d  = bus.wave_sel;
      end

      acc_sum    = {1'b0, acc_q} + {1'b0, freq_q};
      acc_d      = acc_q;
      s0_vld_d   = 1'b0;
      s0_carry_d = 1'b0;
      if (bus.phase_clr) begin
         acc_d = '0;
      end else if (bus.en) begin
         acc_d      = acc_sum[PHASE_W-1:0];
         s0_vld_d   = 1'b1;
         s0_carry_d = acc_sum[PHASE_W];
      end
      // Offset and shape are snapshotted with the token so later cfg_we cannot touch it.
      s0_sel_d = sel_q;
      s0_ofs_d = ofs_q;

      s1_vld_d  = s0_vld_q;
      s1_wrap_d = s0_carry_q;
      s1_sel_d  = s0_sel_q;
      s1_idx_d  = acc_q[PHASE_W-1 -: ADDR_W] + s0_ofs_q;

      raddr     = s1_idx_q[ADDR_W-2] ? ~s1_idx_q[ADDR_W-3:0] : s1_idx_q[ADDR_W-3:0];
      s2_vld_d  = s1_vld_q;
      s2_wrap_d = s1_wrap_q;
      s2_sel_d  = s1_sel_q;
      s2_idx_d  = s1_idx_q;
      s2_rom_d  = rom[raddr];
   end

   // Triangle folds to ADDR_W-1 bits, then is rescaled to the full output range.
   always_comb begin
      tri_t = s2_idx_q[ADDR_W-1] ? ~s2_idx_q[ADDR_W-2:0] : s2_idx_q[ADDR_W-2:0];
      wave  = '0;
      unique case (s2_sel_q)
         2'd0: wave = s2_idx_q[ADDR_W-1] ? MidM1 - s2_rom_q : Mid + s2_rom_q;
         2'd1: wave = s2_idx_q[ADDR_W-1] ? '0 : '1;
         2'd2: wave = DATA_W'({tri_t, {DATA_W{1'b0}}} >> (ADDR_W - 1));
         2'd3: wave = DATA_W'({s2_idx_q, {DATA_W{1'b0}}} >> ADDR_W);
      endcase
   end

`ifdef DDS_AMP_SCALE_EN
   localparam int unsigned SW = DATA_W + 10;

   logic              s3_vld_q, s3_vld_d, s3_wrap_q, s3_wrap_d;
   logic [DATA_W-1:0] s3_x_q, s3_x_d;
   logic [7:0]        s3_amp_q, s3_amp_d;
   logic signed [SW-1:0] amp_prod, amp_res;

   always_comb begin
      s3_vld_d  = s2_vld_q;
      s3_wrap_d = s2_wrap_q;
      s3_x_d    = s2_vld_q ? wave : s3_x_q;
      s3_amp_d  = s2_vld_q ? bus.amp : s3_amp_q;

      amp_prod = ($signed(SW'(s3_x_q)) - $signed(SW'(MidInt))) * $signed(SW'(s3_amp_q));
      amp_res  = $signed(SW'(MidInt)) + (amp_prod >>> 8);
      dout_d   = dout_q;
      if (s3_vld_q) begin
         if (amp_res < 0) begin
            dout_d = '0;
         end else if (amp_res > $signed(SW'(2 ** DATA_W - 1))) begin
            dout_d = '1;
         end else begin
            dout_d = amp_res[DATA_W-1:0];
         end
      end
      vld_d  = s3_vld_q;
      wrap_d = s3_vld_q & s3_wrap_q;
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         s3_vld_q  <= 1'b0;
         s3_wrap_q <= 1'b0;
         s3_x_q    <= '0;
         s3_amp_q  <= '0;
      end else begin
         s3_vld_q  <= s3_vld_d;
         s3_wrap_q <= s3_wrap_d;
         s3_x_q    <= s3_x_d;
         s3_amp_q  <= s3_amp_d;
      end
   end
`else
   logic unused_amp;
   assign unused_amp = ^bus.amp;

   always_comb begin
      dout_d = s2_vld_q ? wave : dout_q;
      vld_d  = s2_vld_q;
      wrap_d = s2_vld_q & s2_wrap_q;
   end
`endif

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         freq_q     <= '0;
         ofs_q      <= '0;
         sel_q      <= '0;
         acc_q      <= '0;
         s0_vld_q   <= 1'b0;
         s0_carry_q <= 1'b0;
         s0_sel_q   <= '0;
         s0_ofs_q   <= '0;
         s1_vld_q   <= 1'b0;
         s1_wrap_q  <= 1'b0;
         s1_sel_q   <= '0;
         s1_idx_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_wrap_q  <= 1'b0;
         s2_sel_q   <= '0;
         s2_idx_q   <= '0;
         s2_rom_q   <= '0;
         dout_q     <= '0;
         vld_q      <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         freq_q     <= freq_d;
         ofs_q      <= ofs_d;
         sel_q      <= sel_d;
         acc_q      <= acc_d;
         s0_vld_q   <= s0_vld_d;
         s0_carry_q <= s0_carry_d;
         s0_sel_q   <= s0_sel_d;
         s0_ofs_q   <= s0_ofs_d;
         s1_vld_q   <= s1_vld_d;
         s1_wrap_q  <= s1_wrap_d;
         s1_sel_q   <= s1_sel_d;
         s1_idx_q   <= s1_idx_d;
         s2_vld_q   <= s2_vld_d;
         s2_wrap_q  <= s2_wrap_d;
         s2_sel_q   <= s2_sel_d;
         s2_idx_q   <= s2_idx_d;
         s2_rom_q   <= s2_rom_d;
         dout_q     <= dout_d;
         vld_q      <= vld_d;
         wrap_q     <= wrap_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_vld   = vld_q;
   assign bus.phase_wrap = wrap_q;
endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: reference model feeds a scoreboard queue checked on dout_vld.
module tb_dds_wave_gen;
`ifdef DDS_AMP_SCALE_EN
   localparam int Lat = 4;
`else
   localparam int Lat = 3;
`endif

   typedef struct {
      int dout;
      int wrap;
      int due;
      int idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dds_wave_gen_if #(.PHASE_W(32), .ADDR_W(10), .DATA_W(10)) bus ();

   dds_wave_gen #(.PHASE_W(32), .ADDR_W(10), .DATA_W(10)) dut (
      .clka  (clk),
      .rsta_n(rst_n),
      .bus   (bus)
   );

   exp_t        sbq[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          rom_m[256];
   int          obs[1024];
   int          wrap_cnt = 0;
   bit          capture = 1'b0;
   logic [31:0] m_acc = '0;
   logic [31:0] m_freq = '0;
   int          m_ofs = 0;
   int          m_sel = 0;

   task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      checks++;
      assert (obs_v === exp_v) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs_v, exp_v);
      end
   endtask

   function automatic int exp_wave(input int idx, input int sel);
      int r;
      case (sel)
         0: begin
            r = rom_m[((idx >> 8) & 1) != 0 ? 255 - (idx & 255) : (idx & 255)];
            return (idx < 512) ? 512 + r : 511 - r;
         end
         1: return (idx < 512) ? 1023 : 0;
         2: return 2 * ((idx >= 512) ? 511 - (idx & 511) : (idx & 511));
         default: return idx;
      endcase
   endfunction

   function automatic int amp_scale(input int x, input int a);
      int p, q, v;
      p = (x - 512) * a;
      q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
      v = 512 + q;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      return v;
   endfunction

   task automatic model_push();
      logic [32:0] s;
      int idx, x;
      if (rst_n !== 1'b1) return;
      if (bus.phase_clr) begin
         m_acc = '0;
      end else if (bus.en) begin
         s     = {1'b0, m_acc} + {1'b0, m_freq};
         m_acc = s[31:0];
         idx   = (int'(m_acc[31:22]) + m_ofs) % 1024;
         x     = exp_wave(idx, m_sel);
`ifdef DDS_AMP_SCALE_EN
         x = amp_scale(x, int'(bus.amp));
`endif
         sbq.push_back('{x, int'(s[32]), cyc + 1 + Lat, idx});
      end
      if (bus.cfg_we) begin
         m_freq = bus.freq_word;
         m_ofs  = int'(bus.phase_ofs);
         m_sel  = int'(bus.wave_sel);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (bus.dout_vld === 1'b1) begin
         if (sbq.size() == 0) begin
            check("vld_unexpected", 32'(bus.dout_vld), 0);
         end else begin
            e = sbq.pop_front();
            check("dout", 32'(bus.dout), e.dout);
            check("phase_wrap", 32'(bus.phase_wrap), e.wrap);
            check("latency", cyc, e.due);
            if (capture) begin
               obs[e.idx] = int'(bus.dout);
               if (bus.phase_wrap) wrap_cnt++;
            end
         end
      end else begin
         check("wrap_idle", 32'(bus.phase_wrap), 0);
         if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            check("vld_missing", 32'(bus.dout_vld), 1);
            sbq.delete(0);
         end
      end
   endtask

   task automatic tick();
      model_push();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_out();
   endtask

   task automatic cfg(input logic [31:0] f, input int ofs, input int sel);
      bus.cfg_we    = 1'b1;
      bus.freq_word = f;
      bus.phase_ofs = 10'(ofs);
      bus.wave_sel  = 2'(sel);
      tick();
      bus.cfg_we = 1'b0;
   endtask

   task automatic clr();
      bus.phase_clr = 1'b1;
      tick();
      bus.phase_clr = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && sbq.size() > 0; i++) tick();
      check("drain_empty", sbq.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom_m[i] = $rtoi(511.0 * $sin(3.14159265358979 * (real'(i) + 0.5) / 512.0) + 0.5);
      end
      rst_n         = 1'b0;
      bus.en        = 1'b0;
      bus.phase_clr = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.freq_word = '0;
      bus.phase_ofs = '0;
      bus.wave_sel  = '0;
      bus.amp       = 8'd128;
      repeat (3) tick();
      check("rst_dout", 32'(bus.dout), 0);
      check("rst_vld", 32'(bus.dout_vld), 0);
      check("rst_wrap", 32'(bus.phase_wrap), 0);
      rst_n = 1'b1;

      // Full sine cycle, idx 1..1023 then 0 with the carry.
      cfg(32'h0040_0000, 0, 0);
      clr();
      capture = 1'b1;
      bus.en  = 1'b1;
      repeat (1024) tick();
      bus.en = 1'b0;
      drain();
      capture = 1'b0;
      check("sine_255_eq_256", obs[255], obs[256]);
`ifndef DDS_AMP_SCALE_EN
      check("sine_peak", obs[255], 512 + rom_m[255]);
      foreach (obs[k]) if (k < 512 && (k % 97) == 0) check("sine_sym", obs[k] + obs[k + 512], 1023);
`endif
      check("wrap_count", wrap_cnt, 1);

      // Quarter-cycle steps: square, sawtooth, triangle.
      foreach (rom_m[s]) begin
         if (s >= 1 && s <= 3) begin
            cfg(32'h4000_0000, 0, s);
            clr();
            bus.en = 1'b1;
            repeat (8) tick();
            bus.en = 1'b0;
         end
      end
      drain();

      // cfg_we with en uses old config; phase_clr beats en and launches nothing.
      cfg(32'h0040_0000, 0, 0);
      clr();
      bus.en = 1'b1;
      repeat (3) tick();
      bus.cfg_we    = 1'b1;
      bus.freq_word = 32'h0100_0000;
      bus.phase_ofs = 10'd5;
      bus.wave_sel  = 2'd3;
      tick();
      bus.cfg_we = 1'b0;
      repeat (4) tick();
      bus.phase_clr = 1'b1;
      tick();
      bus.phase_clr = 1'b0;
      repeat (3) tick();
      bus.en = 1'b0;
      drain();

      // freq_word = 0 holds the index; samples still produced.
      cfg(32'h0, 17, 3);
      bus.en = 1'b1;
      repeat (4) tick();
      bus.en = 1'b0;
      drain();

      for (int i = 0; i < 300; i++) begin
         bus.en        = ($urandom % 4) != 0;
         bus.phase_clr = ($urandom % 16) == 0;
         bus.cfg_we    = ($urandom % 8) == 0;
         bus.freq_word = $urandom;
         bus.phase_ofs = 10'($urandom);
         bus.wave_sel  = 2'($urandom);
         tick();
      end
      bus.en = 1'b0;
      bus.phase_clr = 1'b0;
      bus.cfg_we = 1'b0;
      drain();

`ifdef DDS_AMP_SCALE_EN
      bus.amp = 8'd0;
      cfg(32'h4000_0000, 0, 1);
      bus.en = 1'b1;
      repeat (4) tick();
      bus.en = 1'b0;
      drain();
      bus.amp = 8'd128;
`endif

      // Reset mid-stream with en held high flushes the pipeline immediately.
      cfg(32'h0040_0000, 0, 2);
      bus.en = 1'b1;
      repeat (Lat + 2) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_dout", 32'(bus.dout), 0);
      check("midrst_vld", 32'(bus.dout_vld), 0);
      sbq.delete();
      m_acc  = '0;
      m_freq = '0;
      m_ofs  = 0;
      m_sel  = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      bus.en = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end
endmodule
